// File: rtl/tb_run_controller_if.sv
// Bus between the run controller and whoever drives/observes it.
// The controller attaches through the slave modport; the bench side uses master.
interface tb_run_controller_if;
  logic        i_start;
  logic        i_abort;
  logic [31:0] i_run_len;
  logic [31:0] i_data_ctr;
  logic [31:0] i_error_ctr;
  logic [31:0] i_maxacc;
  logic [31:0] i_minacc;
  logic        o_tb_reset;
  logic        o_tb_enable;
  logic        o_tb_freeze;
  logic        o_busy;
  logic        o_done;
  logic        o_pass;
  logic        o_timeout;
  logic [31:0] o_res_data;
  logic [31:0] o_res_error;
  logic [31:0] o_res_maxacc;
  logic [31:0] o_res_minacc;
  logic [2:0]  o_state;

  modport master (
    output i_start, i_abort, i_run_len, i_data_ctr, i_error_ctr, i_maxacc, i_minacc,
    input  o_tb_reset, o_tb_enable, o_tb_freeze, o_busy, o_done, o_pass, o_timeout,
           o_res_data, o_res_error, o_res_maxacc, o_res_minacc, o_state
  );

  modport slave (
    input  i_start, i_abort, i_run_len, i_data_ctr, i_error_ctr, i_maxacc, i_minacc,
    output o_tb_reset, o_tb_enable, o_tb_freeze, o_busy, o_done, o_pass, o_timeout,
           o_res_data, o_res_error, o_res_maxacc, o_res_minacc, o_state
  );
endinterface

// File: rtl/tb_run_controller.sv
// Run sequencer for an arithmetic testbench: reset -> run to a target sample
// count -> freeze and settle -> snapshot results.
// Optional stall watchdog enabled by defining TB_RUN_TIMEOUT_EN.
module tb_run_controller #(
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk_dut,
  input  logic               reset,
  tb_run_controller_if.slave bus
);

  localparam int unsigned PH_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] RST_LOAD    = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0] SETTLE_LOAD = PH_W'(SETTLE_CYCLES - 1);

  // Elaboration guard on the cycle-count parameters
  if (RST_CYCLES == 0 || SETTLE_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("tb_run_controller: RST_CYCLES, SETTLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_RUN    = 3'd2,
    ST_FREEZE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  state_e          state_q;
  logic [PH_W-1:0] cnt_q;
  logic [31:0]     run_len_q;
  logic            ge_q;
  logic            to_flag_q;
  logic            tb_reset_q;
  logic            tb_enable_q;
  logic            tb_freeze_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic            timeout_q;
  logic [31:0]     res_data_q;
  logic [31:0]     res_error_q;
  logic [31:0]     res_maxacc_q;
  logic [31:0]     res_minacc_q;
  logic            stall_hit_c;

`ifdef TB_RUN_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] stall_q;
  logic [31:0]     prev_data_q;

  assign stall_hit_c = (stall_q == TO_W'(TIMEOUT_CYCLES));

  // Stall watchdog: counts RUN cycles with no change on the data counter, saturating
  always_ff @(posedge clk_dut) begin
    if (reset) begin
      stall_q     <= '0;
      prev_data_q <= '0;
    end else begin
      prev_data_q <= bus.i_data_ctr;
      if (state_q != ST_RUN || bus.i_data_ctr != prev_data_q) begin
        stall_q <= '0;
      end else if (!stall_hit_c) begin
        stall_q <= stall_q + TO_W'(1);
      end
    end
  end
`else
  assign stall_hit_c = 1'b0;
`endif

  // Run sequencer with all outputs registered alongside the state
  always_ff @(posedge clk_dut) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      run_len_q    <= '0;
      ge_q         <= 1'b0;
      to_flag_q    <= 1'b0;
      tb_reset_q   <= 1'b1;
      tb_enable_q  <= 1'b0;
      tb_freeze_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      res_data_q   <= '0;
      res_error_q  <= '0;
      res_maxacc_q <= '0;
      res_minacc_q <= '0;
    end else if (bus.i_abort && busy_q) begin
      // busy_q is high exactly in RESET/RUN/FREEZE; results are left untouched
      state_q     <= ST_IDLE;
      ge_q        <= 1'b0;
      to_flag_q   <= 1'b0;
      tb_reset_q  <= 1'b1;
      tb_enable_q <= 1'b0;
      tb_freeze_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.i_start && !bus.i_abort) begin
            state_q     <= ST_RESET;
            cnt_q       <= RST_LOAD;
            run_len_q   <= (bus.i_run_len == 32'd0) ? 32'd1 : bus.i_run_len;
            tb_reset_q  <= 1'b1;
            tb_enable_q <= 1'b0;
            tb_freeze_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
          end
        end
        ST_RESET: begin
          if (cnt_q == '0) begin
            state_q     <= ST_RUN;
            ge_q        <= 1'b0;
            to_flag_q   <= 1'b0;
            tb_reset_q  <= 1'b0;
            tb_enable_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - PH_W'(1);
          end
        end
        ST_RUN: begin
          ge_q <= (bus.i_data_ctr >= run_len_q);
          if (ge_q || stall_hit_c) begin
            state_q     <= ST_FREEZE;
            cnt_q       <= SETTLE_LOAD;
            to_flag_q   <= stall_hit_c && !ge_q;
            tb_enable_q <= 1'b0;
            tb_freeze_q <= 1'b1;
          end
        end
        ST_FREEZE: begin
          if (cnt_q == '0) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            pass_q       <= (bus.i_error_ctr == 32'd0) && !to_flag_q;
            timeout_q    <= to_flag_q;
            res_data_q   <= bus.i_data_ctr;
            res_error_q  <= bus.i_error_ctr;
            res_maxacc_q <= bus.i_maxacc;
            res_minacc_q <= bus.i_minacc;
          end else begin
            cnt_q <= cnt_q - PH_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Drive the interface from the output registers
  assign bus.o_tb_reset   = tb_reset_q;
  assign bus.o_tb_enable  = tb_enable_q;
  assign bus.o_tb_freeze  = tb_freeze_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_pass       = pass_q;
`ifdef TB_RUN_TIMEOUT_EN
  assign bus.o_timeout    = timeout_q;
`else
  assign bus.o_timeout    = 1'b0;
`endif
  assign bus.o_res_data   = res_data_q;
  assign bus.o_res_error  = res_error_q;
  assign bus.o_res_maxacc = res_maxacc_q;
  assign bus.o_res_minacc = res_minacc_q;
  assign bus.o_state      = state_q;

endmodule
